// File: rtl/arbitro_escritura_rf.sv
// Round-robin arbiter for the single write port of the register file.
// Two valid/ready requesters; WE/DE/DATO are registered (1-cycle latency).
module arbitro_escritura_rf #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 5,
  parameter bit PROTEGE_R0 = 1'b1,
  parameter int ANCHO_CONT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  VALID0,
  input  logic [ANCHO_DIR-1:0]  DE0,
  input  logic [ANCHO_DATO-1:0] DATO0,
  output logic                  READY0,
  input  logic                  VALID1,
  input  logic [ANCHO_DIR-1:0]  DE1,
  input  logic [ANCHO_DATO-1:0] DATO1,
  output logic                  READY1,
  output logic                  WE,
  output logic [ANCHO_DIR-1:0]  DE,
  output logic [ANCHO_DATO-1:0] DATO,
  output logic                  ULTIMO,
  output logic [ANCHO_CONT-1:0] CONFLICTOS
);

  logic                  prio_q, prio_d;
  logic                  we_q, we_d;
  logic [ANCHO_DIR-1:0]  de_q, de_d;
  logic [ANCHO_DATO-1:0] dato_q, dato_d;
  logic                  ultimo_q, ultimo_d;
  logic [ANCHO_CONT-1:0] conf_q, conf_d;

  logic grant0, grant1;
  logic [ANCHO_DIR-1:0]  de_sel;
  logic [ANCHO_DATO-1:0] dato_sel;

  // Ties go to the requester named by prio_q; grants are masked during reset.
  assign grant0 = !RST && VALID0 && (!VALID1 || !prio_q);
  assign grant1 = !RST && VALID1 && (!VALID0 ||  prio_q);
  assign READY0 = grant0;
  assign READY1 = grant1;

  assign de_sel   = grant1 ? DE1   : DE0;
  assign dato_sel = grant1 ? DATO1 : DATO0;

  always_comb begin
    prio_d   = prio_q;
    we_d     = 1'b0;
    de_d     = de_q;
    dato_d   = dato_q;
    ultimo_d = ultimo_q;
    conf_d   = conf_q;
    if (grant0 || grant1) begin
      // Writes to r0 still complete the handshake but never reach the file.
      we_d     = !(PROTEGE_R0 && (de_sel == '0));
      de_d     = de_sel;
      dato_d   = dato_sel;
      ultimo_d = grant1;
      prio_d   = !grant1;
    end
    if (VALID0 && VALID1 && (conf_q != {ANCHO_CONT{1'b1}}))
      conf_d = conf_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q   <= 1'b0;
      we_q     <= 1'b0;
      de_q     <= '0;
      dato_q   <= '0;
      ultimo_q <= 1'b0;
      conf_q   <= '0;
    end else begin
      prio_q   <= prio_d;
      we_q     <= we_d;
      de_q     <= de_d;
      dato_q   <= dato_d;
      ultimo_q <= ultimo_d;
      conf_q   <= conf_d;
    end
  end

  assign WE         = we_q;
  assign DE         = de_q;
  assign DATO       = dato_q;
  assign ULTIMO     = ultimo_q;
  assign CONFLICTOS = conf_q;

endmodule

// File: tb/tb_arbitro_escritura_rf.sv
// Directed bench: default instance (a) plus an unprotected, 2-bit-counter instance (b)
// sharing the same requester stimulus.
module tb_arbitro_escritura_rf;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VALID0, VALID1;
  logic [4:0]  DE0, DE1;
  logic [31:0] DATO0, DATO1;

  logic        ready0_a, ready1_a, we_a, ult_a;
  logic [4:0]  de_a;
  logic [31:0] dato_a;
  logic [15:0] conf_a;

  logic        ready0_b, ready1_b, we_b, ult_b;
  logic [4:0]  de_b;
  logic [31:0] dato_b;
  logic [1:0]  conf_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  arbitro_escritura_rf dut_a (
    .CLK(CLK), .RST(RST),
    .VALID0(VALID0), .DE0(DE0), .DATO0(DATO0), .READY0(ready0_a),
    .VALID1(VALID1), .DE1(DE1), .DATO1(DATO1), .READY1(ready1_a),
    .WE(we_a), .DE(de_a), .DATO(dato_a), .ULTIMO(ult_a), .CONFLICTOS(conf_a)
  );

  arbitro_escritura_rf #(.PROTEGE_R0(1'b0), .ANCHO_CONT(2)) dut_b (
    .CLK(CLK), .RST(RST),
    .VALID0(VALID0), .DE0(DE0), .DATO0(DATO0), .READY0(ready0_b),
    .VALID1(VALID1), .DE1(DE1), .DATO1(DATO1), .READY1(ready1_b),
    .WE(we_b), .DE(de_b), .DATO(dato_b), .ULTIMO(ult_b), .CONFLICTOS(conf_b)
  );

  task automatic do_reset();
    RST = 1'b1; VALID0 = 1'b0; VALID1 = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; VALID0 = 1'b1; VALID1 = 1'b1;
    DE0 = 5'd1; DE1 = 5'd2; DATO0 = 32'h11; DATO1 = 32'h22;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      vectors++;
      if ({we_a, conf_a} !== 17'd0) begin
        miscompares++;
        $display("FAIL reset_we_conf cyc%0d got we=%0b conf=%0d exp we=0 conf=0", c, we_a, conf_a);
      end
      vectors++;
      if ({de_a, dato_a, ult_a} !== 38'd0) begin
        miscompares++;
        $display("FAIL reset_regs cyc%0d got de=%0d dato=%h ult=%0b exp 0", c, de_a, dato_a, ult_a);
      end
      @(negedge CLK);
      vectors++;
      if ({ready0_a, ready1_a, ready0_b, ready1_b} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_ready cyc%0d got %b exp 0000", c,
                 {ready0_a, ready1_a, ready0_b, ready1_b});
      end
    end
    @(posedge CLK); #1;
    RST = 1'b0; VALID0 = 1'b0; VALID1 = 1'b0;
  endtask

  task automatic test_single();
    VALID0 = 1'b1; DE0 = 5'd5; DATO0 = 32'hDEADBEEF; VALID1 = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({ready0_a, ready1_a} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ready got %b exp 10", {ready0_a, ready1_a});
    end
    @(posedge CLK); #1;
    VALID0 = 1'b0;
    vectors++;
    if ({we_a, de_a, dato_a, ult_a} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
      miscompares++;
      $display("FAIL single_write got we=%0b de=%0d dato=%h ult=%0b exp we=1 de=5 dato=deadbeef ult=0",
               we_a, de_a, dato_a, ult_a);
    end
    @(posedge CLK); #1;
    vectors++;
    if ({we_a, de_a, dato_a} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL single_after got we=%0b de=%0d dato=%h exp we=0 de=5 dato=deadbeef",
               we_a, de_a, dato_a);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g;
    exp_g = 4'b1010;  // bit c: 1 -> requester 1 wins cycle c
    do_reset();
    VALID0 = 1'b1; VALID1 = 1'b1;
    DE0 = 5'd3; DATO0 = 32'hAAAA0000; DE1 = 5'd7; DATO1 = 32'hBBBB1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      vectors++;
      if ({ready0_a, ready1_a} !== {!exp_g[c], exp_g[c]}) begin
        miscompares++;
        $display("FAIL contention_ready cyc%0d got %b exp %b", c, {ready0_a, ready1_a},
                 {!exp_g[c], exp_g[c]});
      end
      @(posedge CLK); #1;
      vectors++;
      if ({we_a, ult_a, de_a} !== {1'b1, exp_g[c], exp_g[c] ? 5'd7 : 5'd3}) begin
        miscompares++;
        $display("FAIL contention_write cyc%0d got we=%0b ult=%0b de=%0d exp we=1 ult=%0b",
                 c, we_a, ult_a, de_a, exp_g[c]);
      end
      vectors++;
      if (conf_a !== 16'(c + 1)) begin
        miscompares++;
        $display("FAIL contention_conf cyc%0d got %0d exp %0d", c, conf_a, c + 1);
      end
    end
    VALID0 = 1'b0; VALID1 = 1'b0;
  endtask

  task automatic test_r0_protect();
    VALID0 = 1'b0; VALID1 = 1'b1; DE1 = 5'd0; DATO1 = 32'h1;
    @(negedge CLK);
    vectors++;
    if ({ready0_a, ready1_a} !== 2'b01) begin
      miscompares++;
      $display("FAIL r0_ready got %b exp 01", {ready0_a, ready1_a});
    end
    @(posedge CLK); #1;
    VALID1 = 1'b0;
    vectors++;
    if ({we_a, ult_a, de_a, dato_a} !== {1'b0, 1'b1, 5'd0, 32'h1}) begin
      miscompares++;
      $display("FAIL r0_protected got we=%0b ult=%0b de=%0d dato=%h exp we=0 ult=1 de=0 dato=1",
               we_a, ult_a, de_a, dato_a);
    end
    vectors++;
    if ({we_b, ult_b, de_b} !== {1'b1, 1'b1, 5'd0}) begin
      miscompares++;
      $display("FAIL r0_unprotected got we=%0b ult=%0b de=%0d exp we=1 ult=1 de=0", we_b, ult_b, de_b);
    end
  endtask

  task automatic test_fairness();
    // Requester 1 raises VALID every 3rd cycle and holds it until granted.
    logic [8:0] v1_mask, g1_mask;
    v1_mask = 9'b001001011;  // cycles 0,1,3,6
    g1_mask = 9'b001001010;  // grants to 1 at cycles 1,3,6
    do_reset();
    VALID0 = 1'b1; DE0 = 5'd9; DATO0 = 32'h0;
    DE1 = 5'd10; DATO1 = 32'h1;
    for (int c = 0; c < 9; c++) begin
      VALID1 = v1_mask[c];
      @(negedge CLK);
      vectors++;
      if ({ready0_a, ready1_a} !== {!g1_mask[c], g1_mask[c]}) begin
        miscompares++;
        $display("FAIL fairness_ready cyc%0d got %b exp %b", c, {ready0_a, ready1_a},
                 {!g1_mask[c], g1_mask[c]});
      end
      @(posedge CLK); #1;
      vectors++;
      if ({we_a, ult_a} !== {1'b1, g1_mask[c]}) begin
        miscompares++;
        $display("FAIL fairness_write cyc%0d got we=%0b ult=%0b exp we=1 ult=%0b",
                 c, we_a, ult_a, g1_mask[c]);
      end
    end
    VALID0 = 1'b0; VALID1 = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c;
    do_reset();
    VALID0 = 1'b1; VALID1 = 1'b1; DE0 = 5'd1; DE1 = 5'd2;
    for (int c = 0; c < 6; c++) begin
      exp_c = (c < 3) ? 2'(c + 1) : 2'd3;
      @(posedge CLK); #1;
      vectors++;
      if (conf_b !== exp_c) begin
        miscompares++;
        $display("FAIL saturation_conf cyc%0d got %0d exp %0d", c, conf_b, exp_c);
      end
    end
    VALID0 = 1'b0; VALID1 = 1'b0;
  endtask

  task automatic test_reset_midway();
    do_reset();
    VALID0 = 1'b1; DE0 = 5'd4; DATO0 = 32'hCAFE; RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if (ready0_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_ready got %0b exp 0", ready0_a);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    vectors++;
    if ({we_a, de_a} !== {1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL midreset_discard got we=%0b de=%0d exp we=0 de=0", we_a, de_a);
    end
    @(posedge CLK); #1;
    VALID0 = 1'b0;
    vectors++;
    if ({we_a, de_a, dato_a} !== {1'b1, 5'd4, 32'hCAFE}) begin
      miscompares++;
      $display("FAIL midreset_retry got we=%0b de=%0d dato=%h exp we=1 de=4 dato=cafe",
               we_a, de_a, dato_a);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_r0_protect();
    test_fairness();
    test_saturation();
    test_reset_midway();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
